// File: rtl/fifo_pkg.sv
// Shared helpers and types for the single-clock parametrised FIFO.
// Optional feature macro: SYNC_FIFO_FWFT_EN (first-word-fall-through read port).
package fifo_pkg;

    // Default configuration, matching the reference build of sync_fifo_param.
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_AF_LEVEL = 12;
    localparam int DEF_AE_LEVEL = 2;

    // Number of RAM address bits needed for a given depth.
    function automatic int fifoAddrW(input int depth);
        return $clog2(depth);
    endfunction

    // True when v is a non-zero power of two.
    function automatic bit isPow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Almost-full / almost-empty thresholds must sit inside the occupancy range
    // and must not overlap, otherwise both flags could be set at once.
    function automatic bit levelsValid(input int depth, input int af, input int ae);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae < depth) && (ae < af);
    endfunction

    localparam int DEF_ADDR_W = fifoAddrW(DEF_DEPTH);

    // Pointers carry one extra wrap bit above the RAM index; occupancy needs the
    // same width to represent the full value DEPTH.
    typedef logic [DEF_ADDR_W:0] ptr_t;
    typedef logic [DEF_ADDR_W:0] cnt_t;

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port storage for sync_fifo_param: one write port, one read port.
// Read port is asynchronous when SYNC_FIFO_FWFT_EN is defined, registered otherwise.
module fifo_dpram
    import fifo_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = fifoAddrW(DEPTH)
) (
    input  logic              clk,
`ifndef SYNC_FIFO_FWFT_EN
    input  logic              rst,
    input  logic              re,
`endif
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; storage is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Fall-through read: the word at the read pointer is always visible.
    assign rdata = mem[raddr];
`else
    logic [DATA_W-1:0] rdata_q;

    // Registered read: a word is fetched only on an accepted pop and held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
// Optional feature macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through output.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int AF_LEVEL = DEF_AF_LEVEL,
    parameter  int AE_LEVEL = DEF_AE_LEVEL,
    localparam int ADDR_W   = fifoAddrW(DEPTH),
    localparam int CNT_W    = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              push,
    output logic              full,
    output logic [DATA_W-1:0] data_out,
    input  logic              pop,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    input  logic              clr_err,
    output logic              overflow,
    output logic              underflow
);

    // Reject configurations the pointer arithmetic or flag logic cannot handle.
    if (!isPow2(DEPTH) || DEPTH < 4) begin : gDepthCheck
        $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
    end
    if (!levelsValid(DEPTH, AF_LEVEL, AE_LEVEL)) begin : gLevelCheck
        $error("sync_fifo_param: AF_LEVEL/AE_LEVEL out of range or overlapping");
    end

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    logic [ADDR_W:0]   wrPtr_q, wrPtr_d;
    logic [ADDR_W:0]   rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              almostFull_q, almostFull_d;
    logic              almostEmpty_q, almostEmpty_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              pushAcc;
    logic              popAcc;
    logic [DATA_W-1:0] rdData;

    // Handshake decisions use only registered flags so they never depend on this cycle's outcome.
    assign pushAcc = push && !full_q;
    assign popAcc  = pop && !empty_q;

    // Next-state: pointers, occupancy, derived flags and sticky error flags.
    always_comb begin
        wrPtr_d       = wrPtr_q;
        rdPtr_d       = rdPtr_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        underflow_d   = underflow_q;

        if (pushAcc) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (popAcc) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end

        case ({pushAcc, popAcc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d        = (count_d == FULL_CNT);
        empty_d       = (count_d == '0);
        almostFull_d  = (count_d >= AF_CNT);
        almostEmpty_d = (count_d <= AE_CNT);

        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (push && full_q) begin
            overflow_d = 1'b1;
        end
        if (pop && empty_q) begin
            underflow_d = 1'b1;
        end
    end

    // State register; reset discards all queued data but leaves RAM contents alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almostFull_q  <= 1'b0;
            almostEmpty_q <= 1'b1;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            almostFull_q  <= almostFull_d;
            almostEmpty_q <= almostEmpty_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    fifo_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) uRam (
        .clk   (clk),
`ifndef SYNC_FIFO_FWFT_EN
        .rst   (rst),
        .re    (popAcc),
`endif
        .we    (pushAcc),
        .waddr (wrPtr_q[ADDR_W-1:0]),
        .wdata (data_in),
        .raddr (rdPtr_q[ADDR_W-1:0]),
        .rdata (rdData)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // While empty the RAM word is stale; show a stable zero instead.
    assign data_out = empty_q ? '0 : rdData;
`else
    assign data_out = rdData;
`endif

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almostFull_q;
    assign almost_empty = almostEmpty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = 12;
    localparam int AE     = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [7:0] data_out;
    logic [4:0] count;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model state: queued words, sticky flags, last popped word.
    logic [7:0] mq[$];
    bit         mOvf = 1'b0;
    bit         mUnf = 1'b0;
    logic [7:0] mData = '0;

    sync_fifo_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .push         (push),
        .full         (full),
        .data_out     (data_out),
        .pop          (pop),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Data the model says should be visible on data_out right now.
    function automatic logic [7:0] expOut();
`ifdef SYNC_FIFO_FWFT_EN
        return (mq.size() > 0) ? mq[0] : 8'h00;
`else
        return mData;
`endif
    endfunction

    // Drive one clock cycle of inputs, advance the model at the edge, settle 1 ns after it.
    task automatic applyStimulus(input logic pushV, input logic popV, input logic clrV,
                                 input logic rstV, input logic [7:0] d);
        bit wasFull, wasEmpty;
        push = pushV; pop = popV; clr_err = clrV; rst = rstV; data_in = d;
        @(posedge clk);
        if (rstV) begin
            mq.delete();
            mOvf = 1'b0; mUnf = 1'b0; mData = 8'h00;
        end else begin
            wasFull  = (mq.size() == DEPTH);
            wasEmpty = (mq.size() == 0);
            if (popV && !wasEmpty) mData = mq.pop_front();
            if (pushV && !wasFull) mq.push_back(d);
            if (pushV && wasFull) mOvf = 1'b1; else if (clrV) mOvf = 1'b0;
            if (popV && wasEmpty) mUnf = 1'b1; else if (clrV) mUnf = 1'b0;
        end
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus(0, 0, 0, 1, 8'h00);
        applyStimulus(0, 0, 0, 1, 8'h00);
        nCompared++; if (count !== 5'd0) begin nMismatched++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        nCompared++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_empty: got e=%b ae=%b want 1 1", empty, almost_empty); end
        nCompared++; if (full !== 1'b0 || almost_full !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_full: got f=%b af=%b want 0 0", full, almost_full); end
        nCompared++; if (overflow !== 1'b0 || underflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_err: got ov=%b un=%b want 0 0", overflow, underflow); end
        nCompared++; if (data_out !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_data: got %h want 00", data_out); end
    endtask

    task automatic test_in_order();
        for (int i = 0; i <= 10; i++) applyStimulus(1, 0, 0, 0, 8'(i));
        nCompared++; if (count !== 5'd11) begin nMismatched++; $display("[TB] FAIL order_count: got %0d want 11", count); end
        for (int i = 0; i <= 10; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            nCompared++; if (data_out !== 8'(i)) begin nMismatched++; $display("[TB] FAIL order_data[%0d]: got %h want %h", i, data_out, 8'(i)); end
`endif
            applyStimulus(0, 1, 0, 0, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
            nCompared++; if (data_out !== 8'(i)) begin nMismatched++; $display("[TB] FAIL order_data[%0d]: got %h want %h", i, data_out, 8'(i)); end
`endif
        end
        nCompared++; if (empty !== 1'b1 || count !== 5'd0) begin nMismatched++; $display("[TB] FAIL order_end: got e=%b c=%0d want 1 0", empty, count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 0, 0, 0, 8'(8'h10 + i));
            if (i == 14) begin
                nCompared++; if (full !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_notfull15: got %b want 0", full); end
            end
            if (i == 15) begin
                nCompared++; if (full !== 1'b1 || count !== 5'd16) begin nMismatched++; $display("[TB] FAIL ovf_full16: got f=%b c=%0d want 1 16", full, count); end
                nCompared++; if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_early: got %b want 0", overflow); end
            end
        end
        nCompared++; if (overflow !== 1'b1 || count !== 5'd16) begin nMismatched++; $display("[TB] FAIL ovf_set: got ov=%b c=%0d want 1 16", overflow, count); end
        for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            nCompared++; if (data_out !== 8'(8'h10 + i)) begin nMismatched++; $display("[TB] FAIL ovf_data[%0d]: got %h want %h", i, data_out, 8'(8'h10 + i)); end
`endif
            applyStimulus(0, 1, 0, 0, 8'h00);
            if (i == 0) begin
                nCompared++; if (full !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_fulldrop: got %b want 0", full); end
            end
`ifndef SYNC_FIFO_FWFT_EN
            nCompared++; if (data_out !== 8'(8'h10 + i)) begin nMismatched++; $display("[TB] FAIL ovf_data[%0d]: got %h want %h", i, data_out, 8'(8'h10 + i)); end
`endif
        end
        nCompared++; if (empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_noextra: got empty=%b want 1", empty); end
    endtask

    task automatic test_underflow();
        applyStimulus(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 0, 8'(i));
        for (int i = 0; i < 21; i++) begin
            applyStimulus(0, 1, 0, 0, 8'h00);
            nCompared++; if (data_out !== expOut()) begin nMismatched++; $display("[TB] FAIL unf_data[%0d]: got %h want %h", i, data_out, expOut()); end
            if (i == 15) begin
                nCompared++; if (underflow !== 1'b0 || empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL unf_early: got un=%b e=%b want 0 1", underflow, empty); end
            end
        end
        nCompared++; if (underflow !== 1'b1 || count !== 5'd0) begin nMismatched++; $display("[TB] FAIL unf_set: got un=%b c=%0d want 1 0", underflow, count); end
`ifndef SYNC_FIFO_FWFT_EN
        nCompared++; if (data_out !== 8'h0F) begin nMismatched++; $display("[TB] FAIL unf_hold: got %h want 0f", data_out); end
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 8'(8'h30 + i));
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 1, 0, 0, 8'($urandom_range(0, 255)));
            nCompared++; if (count !== 5'd8 || data_out !== expOut()) begin nMismatched++; $display("[TB] FAIL b2b[%0d]: got c=%0d d=%h want 8 %h", k, count, data_out, expOut()); end
        end
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0, 8'h00);
    endtask

    task automatic test_levels();
        for (int s = 0; s < 32; s++) begin
            if (s < 16) applyStimulus(1, 0, 0, 0, 8'(s)); else applyStimulus(0, 1, 0, 0, 8'h00);
            nCompared++;
            if (count !== 5'(mq.size()) || almost_empty !== (mq.size() <= AE) || almost_full !== (mq.size() >= AF)) begin
                nMismatched++;
                $display("[TB] FAIL levels[%0d]: got c=%0d ae=%b af=%b want c=%0d ae=%b af=%b", s, count, almost_empty, almost_full, mq.size(), mq.size() <= AE, mq.size() >= AF);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 8'(8'h50 + i));
        applyStimulus(1, 0, 0, 1, 8'h5A);
        nCompared++; if (count !== 5'd0 || empty !== 1'b1 || almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst: got c=%0d e=%b af=%b ov=%b un=%b want 0 1 0 0 0", count, empty, almost_full, overflow, underflow); end
        for (int i = 0; i < 17; i++) applyStimulus(1, 0, 0, 0, 8'(i));
        nCompared++; if (overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL clr_pre: got %b want 1", overflow); end
        applyStimulus(0, 0, 1, 0, 8'h00);
        nCompared++; if (overflow !== 1'b0 || count !== 5'd16) begin nMismatched++; $display("[TB] FAIL clr_err: got ov=%b c=%0d want 0 16", overflow, count); end
        applyStimulus(1, 0, 1, 0, 8'h00);
        nCompared++; if (overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL clr_setwins: got %b want 1", overflow); end
        applyStimulus(0, 0, 0, 1, 8'h00);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom % 100) < 55, ($urandom % 100) < 45, ($urandom % 25) == 0,
                          ($urandom % 150) == 0, 8'($urandom));
            nCompared++;
            if (count !== 5'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) ||
                almost_full !== (mq.size() >= AF) || almost_empty !== (mq.size() <= AE) ||
                overflow !== mOvf || underflow !== mUnf || data_out !== expOut()) begin
                nMismatched++;
                $display("[TB] FAIL rand[%0d]: got c=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b d=%h want c=%0d ov=%b un=%b d=%h",
                         k, count, full, empty, almost_full, almost_empty, overflow, underflow, data_out,
                         mq.size(), mOvf, mUnf, expOut());
            end
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_levels();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
